// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with valid/ready command and response ports.
module apb_master #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    preset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d, psel_q, psel_d, penable_q, penable_d;
  logic                  pwrite_q, pwrite_d, rsp_valid_q, rsp_valid_d;
  logic                  rsp_slverr_q, rsp_slverr_d, rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic                  expired;
  // The counter holds the number of pready-low access cycles already seen
  assign expired = TIMEOUT_CYCLES > 0 && int'(cnt_q) == TIMEOUT_CYCLES - 1;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pstrb_d       = pstrb_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pstrb_d     = cmd_write ? cmd_strb : '0;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready || expired) begin
          state_d       = RESP;
          cnt_d         = '0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pready && !pwrite_q) ? prdata : '0;
          rsp_slverr_d  = pready ? pslverr : 1'b1;
          rsp_timeout_d = !pready;
        end else
          cnt_d = cnt_q + 1'b1;
      end
      default: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pstrb_q       <= pstrb_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pstrb       = pstrb_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed transfers against a cycle-offset model of the APB requester.
module tb_apb_master;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        preset_n, cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr, paddr;
  logic [31:0] cmd_wdata, pwdata, prdata, rsp_rdata;
  logic [3:0]  cmd_strb, pstrb;
  logic        rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic        psel, penable, pwrite, pready, pslverr;
  logic        chk_en = 1'b0;
  logic        exp_cmd_ready, exp_psel, exp_pen, exp_rsp_valid, exp_pwrite, exp_se, exp_to;
  logic [11:0] exp_paddr;
  logic [3:0]  exp_pstrb;
  logic [31:0] exp_pwdata, exp_rdata;
  logic [31:0] last_rdata;
  logic        last_se, last_to;
  int          checks = 0, errors = 0, pen_cnt = 0, a4_cnt = 0;

  always #5 clk = ~clk;

  apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .preset_n(preset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (penable) pen_cnt++;
    if (psel && paddr == 12'h004) a4_cnt++;
    if (rsp_valid) begin
      last_rdata = rsp_rdata;
      last_se    = rsp_slverr;
      last_to    = rsp_timeout;
    end
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      chk("psel", 32'(psel), 32'(exp_psel));
      chk("penable", 32'(penable), 32'(exp_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      if (exp_psel) begin
        chk("pwrite", 32'(pwrite), 32'(exp_pwrite));
        chk("paddr", 32'(paddr), 32'(exp_paddr));
        chk("pstrb", 32'(pstrb), 32'(exp_pstrb));
        chk("pwdata", pwdata, exp_pwdata);
      end
      if (exp_rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_slverr", 32'(rsp_slverr), 32'(exp_se));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      end
    end
  end

  task automatic idle(input int n, input logic pr);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_write = 'x; cmd_addr = 'x; cmd_wdata = 'x; cmd_strb = 'x;
      pready = pr; pslverr = pr; prdata = 32'hFFFF_0000; rsp_ready = 1'b0;
      exp_cmd_ready = 1'b1; exp_psel = 1'b0; exp_pen = 1'b0; exp_rsp_valid = 1'b0;
      chk_en = 1'b1;
    end
  endtask

  // k counts cycles from the handshake cycle; L is the number of access cycles
  task automatic xfer(input logic w, input logic [11:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic [31:0] rd,
                      input logic se, input int rdly, input logic tied, input logic keep,
                      input int rst_at);
    logic to;
    int   len, last;
    to   = TO > 0 && waits >= TO;
    len  = to ? TO : waits + 1;
    last = 2 + len + rdly;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      cmd_valid = k == 0 || keep;
      cmd_write = k == 0 ? w : ~w;
      cmd_addr  = k == 0 ? a : ~a;
      cmd_wdata = k == 0 ? wd : ~wd;
      cmd_strb  = k == 0 ? st : ~st;
      pready    = tied || (k - 2 == waits);
      prdata    = pready ? rd : 32'h5A5A_5A5A;
      pslverr   = pready ? se : 1'b1;
      rsp_ready = k == last;
      exp_cmd_ready = k == 0;
      exp_psel      = k >= 1 && k <= 1 + len;
      exp_pen       = k >= 2 && k <= 1 + len;
      exp_rsp_valid = k >= 2 + len;
      exp_pwrite    = w;
      exp_paddr     = a;
      exp_pstrb     = w ? st : 4'h0;
      exp_pwdata    = w ? wd : 32'h0;
      exp_rdata     = (to || w) ? 32'h0 : rd;
      exp_se        = to ? 1'b1 : se;
      exp_to        = to;
      if (k == rst_at) begin
        chk_en = 1'b0;
        #2 preset_n = 1'b0;
        #1;
        chk("rst_psel", 32'(psel), 32'h0);
        chk("rst_penable", 32'(penable), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        return;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    preset_n = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; prdata = '0;
    #2 preset_n = 1'b0;
    #2;
    chk("init_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("init_psel", 32'(psel), 32'h0);
    chk("init_penable", 32'(penable), 32'h0);
    chk("init_rsp_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk); #2 preset_n = 1'b1;
    idle(2, 1'b0);
    xfer(1'b1, 12'h000, 32'h0000_00A5, 4'h1, 0, 32'h0, 1'b0, 0, 1'b1, 1'b0, -1);
    settle();
    chk("wr_rdata_lit", last_rdata, 32'h0);
    a4_cnt = 0;
    xfer(1'b0, 12'h004, 32'h1111_2222, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b0, -1);
    settle();
    chk("rd_paddr_cycles_lit", 32'(a4_cnt), 32'd5);
    chk("rd_rdata_lit", last_rdata, 32'hDEAD_BEEF);
    xfer(1'b0, 12'hFFC, 32'h0, 4'h0, 0, 32'h1357_9BDF, 1'b1, 0, 1'b0, 1'b0, -1);
    settle();
    chk("err_slverr_lit", 32'(last_se), 32'h1);
    chk("err_rdata_lit", last_rdata, 32'h1357_9BDF);
    pen_cnt = 0;
    xfer(1'b1, 12'h008, 32'h0000_0003, 4'hF, 100, 32'h0, 1'b0, 0, 1'b0, 1'b0, -1);
    settle();
    chk("to_penable_cycles_lit", 32'(pen_cnt), 32'd4);
    chk("to_timeout_lit", 32'(last_to), 32'h1);
    chk("to_slverr_lit", 32'(last_se), 32'h1);
    xfer(1'b1, 12'h00C, 32'h1122_3344, 4'h3, 1, 32'h0, 1'b0, 5, 1'b0, 1'b1, -1);
    xfer(1'b0, 12'h010, 32'h0, 4'h0, 0, 32'h0000_0042, 1'b0, 0, 1'b0, 1'b0, -1);
    xfer(1'b0, 12'h014, 32'h0, 4'h0, 50, 32'h0, 1'b0, 0, 1'b0, 1'b0, 3);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_cmd_ready", 32'(cmd_ready), 32'h0);
    #1 preset_n = 1'b1;
    idle(4, 1'b1);
    xfer(1'b0, 12'h018, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 1'b0, -1);
    idle(2, 1'b0);
    settle();
    chk("final_rdata_lit", last_rdata, 32'hCAFE_F00D);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
